// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - 31x32 integer register file written from MEM/WB, with write-through bypass and retired-instruction counter.
package wb_regfile_pkg;
  localparam int RegWidth     = 32;
  localparam int RegAddrWidth = 5;

  typedef struct packed {
    logic       valid;
    logic       wb_en;
    logic       mem_en;
    logic       ex_en;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
  } ctrl_t;

  typedef struct packed {
    logic [RegAddrWidth-1:0] addr;
    logic [RegWidth-1:0]     data;
  } reg_transport_t;

  typedef struct packed {
    ctrl_t          ctrl;
    reg_transport_t rd;
  } mem_wb_t;
endpackage

module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int INSTRET_W = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  mem_wb_t                 mem_wb,
  input  logic [RegAddrWidth-1:0] rs1_addr,
  input  logic [RegAddrWidth-1:0] rs2_addr,
  output reg_transport_t          rs1,
  output reg_transport_t          rs2,
  output logic [INSTRET_W-1:0]    instret,
  output logic                    wb_fire
);

  logic [RegWidth-1:0]  regs_q [1:31];
  logic [RegWidth-1:0]  regs_d [1:31];
  logic [INSTRET_W-1:0] instret_q;
  logic [INSTRET_W-1:0] instret_d;
  logic                 we;
  logic [RegWidth-1:0]  rs1_reg;
  logic [RegWidth-1:0]  rs2_reg;

  always_comb begin
    we = mem_wb.ctrl.valid & mem_wb.ctrl.wb_en &
         (mem_wb.rd.addr != '0) & ~rst;

    regs_d = regs_q;
    for (int i = 1; i < 32; i++) begin
      if (we && (mem_wb.rd.addr == RegAddrWidth'(i))) begin
        regs_d[i] = mem_wb.rd.data;
      end
    end

    // Retirement counts every valid slot, including x0 and non-writing ones.
    instret_d = instret_q;
    if (mem_wb.ctrl.valid) begin
      instret_d = instret_q + INSTRET_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      instret_q <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      instret_q <= instret_d;
    end
  end

  always_comb begin
    rs1_reg = '0;
    rs2_reg = '0;
    for (int i = 1; i < 32; i++) begin
      if (rs1_addr == RegAddrWidth'(i)) rs1_reg = regs_q[i];
      if (rs2_addr == RegAddrWidth'(i)) rs2_reg = regs_q[i];
    end

    rs1.addr = rs1_addr;
    rs2.addr = rs2_addr;
    rs1.data = '0;
    rs2.data = '0;
    // A commit to the same register in this cycle wins over stored state.
    if (!rst && (rs1_addr != '0)) begin
      rs1.data = (we && (mem_wb.rd.addr == rs1_addr)) ? mem_wb.rd.data : rs1_reg;
    end
    if (!rst && (rs2_addr != '0)) begin
      rs2.data = (we && (mem_wb.rd.addr == rs2_addr)) ? mem_wb.rd.data : rs2_reg;
    end
  end

  assign wb_fire = we;
  assign instret = instret_q;

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter INSTRET_W, default 64, giving the width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port mem_wb, input, mem_wb_t; the MEM/WB pipeline register, which is the write end of this block.
REQ-005 SHALL have port rs1_addr, input, RegAddrWidth; the ID-stage source-1 read address.
REQ-006 SHALL have port rs2_addr, input, RegAddrWidth; the ID-stage source-2 read address.
REQ-007 SHALL have port rs1, output, reg_transport_t; the source-1 operand (addr, data) returned to ID.
REQ-008 SHALL have port rs2, output, reg_transport_t; the source-2 operand (addr, data) returned to ID.
REQ-009 SHALL have port instret, output, INSTRET_W; the count of retired instructions.
REQ-010 SHALL have port wb_fire, output, 1; asserted when a register write commits this cycle.

Function
REQ-011 SHALL hold 31 architectural registers x1..x31, each RegWidth bits; x0 has no storage.
REQ-012 SHALL define the write condition we = mem_wb.ctrl.valid & mem_wb.ctrl.wb_en & (mem_wb.rd.addr != 0) & !rst.
REQ-013 SHALL, when we is high, write regs[mem_wb.rd.addr] <= mem_wb.rd.data at the rising clk edge (1-cycle write latency).
REQ-014 SHALL drive wb_fire = we combinationally.
REQ-015 SHALL ignore a write to x0 silently: no state change and wb_fire = 0.
REQ-016 SHALL perform reads combinationally (0-cycle latency), with rsN.addr = rsN_addr.
REQ-017 SHALL set rsN.data = 0 whenever rsN_addr == 0, regardless of any write.
REQ-018 SHALL, when we is high and mem_wb.rd.addr == rsN_addr != 0, set rsN.data = mem_wb.rd.data (write-through bypass), otherwise regs[rsN_addr].
REQ-019 SHALL let rs1 and rs2 bypass independently, so both may bypass in the same cycle when the addresses are equal.
REQ-020 SHALL increment instret by exactly 1 on every cycle with mem_wb.ctrl.valid = 1 and rst = 0, independent of wb_en and rd.addr.
REQ-021 SHALL wrap instret from all-ones to 0 with no flag or saturation.
REQ-022 SHALL leave state unchanged on a cycle with mem_wb.ctrl.valid = 0, with wb_fire = 0 and no bypass.
REQ-023 SHALL ignore the opcode, func3, func7, mem_en and ex_en fields of mem_wb.ctrl.

Reset
REQ-024 SHALL clear all of x1..x31 to 0 and instret to 0 on a rising edge with rst = 1.
REQ-025 SHALL give reset priority over a simultaneous valid write: the write is dropped and instret does not increment.
REQ-026 SHALL, while rst = 1, drive rs1.data = rs2.data = 0 and wb_fire = 0, with rsN.addr still tracking its input.
REQ-027 SHALL accept writes on the first cycle after rst deasserts.

Verification
REQ-028 SHALL check: write x5 = 0xDEADBEEF, then read rs1_addr = 5 on the next cycle -> rs1.data = 0xDEADBEEF and instret = 1.
REQ-029 SHALL check: write x0 = 0x12345678 with rs1_addr = 0 -> rs1.data = 0, wb_fire = 0 and instret increments by 1.
REQ-030 SHALL check: write x7 = 0xA5A5A5A5 with rs1_addr = rs2_addr = 7 in the same cycle -> both rsN.data = 0xA5A5A5A5 that cycle, and on the following cycle with valid = 0.
REQ-031 SHALL check: valid = 1 with wb_en = 0 and rd.addr = 3 for 4 cycles -> x3 unchanged, instret += 4, wb_fire = 0.
REQ-032 SHALL check: rst = 1 together with a valid write to x9 = 0x55 -> x9 reads 0 after reset and instret = 0.
REQ-033 SHALL check: with instret force-loaded to all-ones (INSTRET_W = 8 build, 0xFF), one valid cycle -> instret = 0x00.
